// File: rtl/range_counter_if.sv
// ============================================================================
// range_counter_if : control/status bundle of the bounded range counter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface range_counter_if #(
  parameter int WIDTH = 5
);
  logic             i_en;
  logic             i_down;
  logic             i_load;
  logic [WIDTH-1:0] i_load_val;
  logic [WIDTH-1:0] o_count;
  logic             o_tc;
  logic             o_done;
  logic             o_dir_down;

  modport master (
    output i_en, i_down, i_load, i_load_val,
    input  o_count, o_tc, o_done, o_dir_down
  );

  modport slave (
    input  i_en, i_down, i_load, i_load_val,
    output o_count, o_tc, o_done, o_dir_down
  );
endinterface

`default_nettype wire

// File: rtl/range_counter.sv
// ============================================================================
// range_counter : bounded BEGIN..END counter, STEP per enable, end action by MODE
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module range_counter #(
  parameter int WIDTH = 5,
  parameter int BEGIN = 0,
  parameter int END   = 31,
  parameter int STEP  = 1,
  parameter int MODE  = 1
) (
  input  logic            clk,
  input  logic            reset,
  range_counter_if.slave  bus
);

  localparam int C_MODE_WRAP    = 1;
  localparam int C_MODE_BOUNCE  = 2;
  localparam int C_MODE_ONESHOT = 3;

  localparam logic [WIDTH:0] C_BEGIN = BEGIN[WIDTH:0];
  localparam logic [WIDTH:0] C_END   = END[WIDTH:0];
  localparam logic [WIDTH:0] C_STEP  = STEP[WIDTH:0];

  // Count kept one bit wider so all range arithmetic happens without overflow.
  logic [WIDTH:0] r_count;
  logic           r_tc;
  logic           r_done;
  logic           r_bdir;

  logic [WIDTH:0] w_next;
  logic [WIDTH:0] w_load_clamped;
  logic [WIDTH:0] w_load_ext;
  logic           w_at_end;
  logic           w_at_begin;
  logic           w_step_down;
  logic           w_step_tc;
  logic           w_bdir_next;

  always_comb begin
    w_next         = r_count;
    w_step_down    = bus.i_down;
    w_at_end       = (r_count == C_END);
    w_at_begin     = (r_count == C_BEGIN);
    w_load_ext     = {1'b0, bus.i_load_val};
    w_load_clamped = w_load_ext;

    if (w_load_ext < C_BEGIN) begin
      w_load_clamped = C_BEGIN;
    end else if (w_load_ext > C_END) begin
      w_load_clamped = C_END;
    end

    // Bounce direction is forced at the bounds so a load to END turns around.
    if (MODE == C_MODE_BOUNCE) begin
      if (w_at_end) begin
        w_step_down = 1'b1;
      end else if (w_at_begin) begin
        w_step_down = 1'b0;
      end else begin
        w_step_down = r_bdir;
      end
    end

    if (!w_step_down) begin
      if ((C_END - r_count) > C_STEP) begin
        w_next = r_count + C_STEP;
      end else if (!w_at_end) begin
        w_next = C_END;
      end else if (MODE == C_MODE_WRAP) begin
        w_next = C_BEGIN;
      end else begin
        w_next = C_END;
      end
    end else begin
      if ((r_count - C_BEGIN) > C_STEP) begin
        w_next = r_count - C_STEP;
      end else if (!w_at_begin) begin
        w_next = C_BEGIN;
      end else if (MODE == C_MODE_WRAP) begin
        w_next = C_END;
      end else begin
        w_next = C_BEGIN;
      end
    end

    w_step_tc = w_step_down ? (w_next == C_BEGIN) : (w_next == C_END);

    if (w_next == C_END) begin
      w_bdir_next = 1'b1;
    end else if (w_next == C_BEGIN) begin
      w_bdir_next = 1'b0;
    end else begin
      w_bdir_next = w_step_down;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= C_BEGIN;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
      r_bdir  <= 1'b0;
    end else if (bus.i_load) begin
      r_count <= w_load_clamped;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
      r_bdir  <= 1'b0;
    end else if (bus.i_en && !r_done) begin
      r_count <= w_next;
      r_tc    <= w_step_tc;
      r_bdir  <= w_bdir_next;
      if ((MODE == C_MODE_ONESHOT) && w_step_tc) begin
        r_done <= 1'b1;
      end
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign bus.o_count    = r_count[WIDTH-1:0];
  assign bus.o_tc       = r_tc;
  assign bus.o_done     = r_done;
  assign bus.o_dir_down = (MODE == C_MODE_BOUNCE) ? r_bdir : bus.i_down;

endmodule

`default_nettype wire

// File: tb/tb_range_counter.sv
// ============================================================================
// tb_range_counter : five range_counter configurations driven from a vector table
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_range_counter;

  // unit 0: WRAP 0..31 S1, 1: SAT 0..9 S4, 2: BOUNCE 2..5 S1, 3: ONESHOT 0..3 S1, 4: WRAP 4..20 S1
  localparam int NU = 5;
  localparam int P_BEGIN [NU] = '{0, 0, 2, 0, 4};
  localparam int P_END   [NU] = '{31, 9, 5, 3, 20};
  localparam int P_STEP  [NU] = '{1, 4, 1, 1, 1};
  localparam int P_MODE  [NU] = '{1, 0, 2, 3, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       t_rst  [NU];
  logic       t_en   [NU];
  logic       t_down [NU];
  logic       t_load [NU];
  logic [4:0] t_lval [NU];
  logic [4:0] s_count[NU];
  logic       s_tc   [NU];
  logic       s_done [NU];
  logic       s_dir  [NU];

  for (genvar g = 0; g < NU; g++) begin : g_dut
    range_counter_if #(.WIDTH(5)) u_if ();
    assign u_if.i_en       = t_en[g];
    assign u_if.i_down     = t_down[g];
    assign u_if.i_load     = t_load[g];
    assign u_if.i_load_val = t_lval[g];
    assign s_count[g]      = u_if.o_count;
    assign s_tc[g]         = u_if.o_tc;
    assign s_done[g]       = u_if.o_done;
    assign s_dir[g]        = u_if.o_dir_down;

    range_counter #(
      .WIDTH(5), .BEGIN(P_BEGIN[g]), .END(P_END[g]),
      .STEP(P_STEP[g]), .MODE(P_MODE[g])
    ) u_dut (
      .clk  (clk),
      .reset(t_rst[g]),
      .bus  (u_if)
    );
  end

  typedef struct {
    int         unit;
    bit         rst, en, down, load;
    logic [4:0] lval;
    logic [4:0] count;
    bit         tc, done, dir;
    string      name;
  } vec_t;

  typedef struct {
    int         unit;
    logic [4:0] count;
    bit         tc, done, dir;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add(input int unit, input bit rst, input bit en, input bit down,
                              input bit load, input int lval, input int cnt,
                              input bit tc, input bit done, input bit dir, input string name);
    vec_t v;
    v.unit = unit; v.rst = rst; v.en = en; v.down = down; v.load = load;
    v.lval = lval[4:0]; v.count = cnt[4:0]; v.tc = tc; v.done = done; v.dir = dir;
    v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic apply(input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      t_rst[u] = 1'b0; t_en[u] = 1'b0; t_load[u] = 1'b0;
    end
    t_rst[v.unit]  = v.rst;
    t_en[v.unit]   = v.en;
    t_down[v.unit] = v.down;
    t_load[v.unit] = v.load;
    t_lval[v.unit] = v.lval;
    e.unit = v.unit; e.count = v.count; e.tc = v.tc; e.done = v.done; e.dir = v.dir;
    e.name = v.name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checks++;
    if (s_count[got.unit] !== got.count || s_tc[got.unit] !== got.tc ||
        s_done[got.unit] !== got.done || s_dir[got.unit] !== got.dir) begin
      failures++;
      $display("FAIL %s: got count=%0d tc=%b done=%b dir=%b, expected count=%0d tc=%b done=%b dir=%b",
               got.name, s_count[got.unit], s_tc[got.unit], s_done[got.unit], s_dir[got.unit],
               got.count, got.tc, got.done, got.dir);
    end
  endtask

  initial begin
    //   unit rst en dn ld lval cnt tc dn dir name
    add(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, "wrap_reset");
    for (int i = 1; i <= 33; i++)
      add(0, 0, 1, 0, 0, 0, i % 32, (i == 31), 0, 0, $sformatf("wrap_step%0d", i));

    add(1, 1, 0, 0, 0, 0,  0, 0, 0, 0, "sat_reset");
    add(1, 0, 1, 0, 0, 0,  4, 0, 0, 0, "sat_up4");
    add(1, 0, 1, 0, 0, 0,  8, 0, 0, 0, "sat_up8");
    add(1, 0, 1, 0, 0, 0,  9, 1, 0, 0, "sat_partial9");
    add(1, 0, 1, 0, 0, 0,  9, 1, 0, 0, "sat_hold9a");
    add(1, 0, 1, 0, 0, 0,  9, 1, 0, 0, "sat_hold9b");
    add(1, 0, 1, 1, 0, 0,  5, 0, 0, 1, "sat_dn5");
    add(1, 0, 1, 1, 0, 0,  1, 0, 0, 1, "sat_dn1");
    add(1, 0, 1, 1, 0, 0,  0, 1, 0, 1, "sat_partial0");
    add(1, 0, 1, 1, 0, 0,  0, 1, 0, 1, "sat_hold0");
    add(1, 0, 0, 1, 0, 0,  0, 0, 0, 1, "sat_idle");

    add(2, 1, 0, 0, 0, 0,  2, 0, 0, 0, "bnc_reset");
    add(2, 0, 1, 0, 0, 0,  3, 0, 0, 0, "bnc_3up");
    add(2, 0, 1, 0, 0, 0,  4, 0, 0, 0, "bnc_4up");
    add(2, 0, 1, 0, 0, 0,  5, 1, 0, 1, "bnc_5top");
    add(2, 0, 1, 0, 0, 0,  4, 0, 0, 1, "bnc_4dn");
    add(2, 0, 1, 0, 0, 0,  3, 0, 0, 1, "bnc_3dn");
    add(2, 0, 1, 0, 0, 0,  2, 1, 0, 0, "bnc_2bot");
    add(2, 0, 1, 1, 0, 0,  3, 0, 0, 0, "bnc_ignore_down");

    add(3, 1, 0, 0, 0, 0,  0, 0, 0, 0, "os_reset");
    add(3, 0, 1, 0, 0, 0,  1, 0, 0, 0, "os_1");
    add(3, 0, 1, 0, 0, 0,  2, 0, 0, 0, "os_2");
    add(3, 0, 1, 0, 0, 0,  3, 1, 1, 0, "os_done");
    add(3, 0, 1, 0, 0, 0,  3, 0, 1, 0, "os_hold_a");
    add(3, 0, 1, 0, 0, 0,  3, 0, 1, 0, "os_hold_b");
    add(3, 0, 1, 0, 1, 1,  1, 0, 0, 0, "os_load1");
    add(3, 0, 1, 0, 0, 0,  2, 0, 0, 0, "os_rearm");
    add(3, 0, 1, 1, 0, 0,  1, 0, 0, 1, "os_dn1");
    add(3, 0, 1, 1, 0, 0,  0, 1, 1, 1, "os_dn_done");
    add(3, 0, 0, 1, 0, 0,  0, 0, 1, 1, "os_idle");
    add(3, 1, 1, 0, 0, 0,  0, 0, 0, 0, "os_reset_clear");

    add(4, 1, 0, 0, 0, 0,  4, 0, 0, 0, "clamp_reset");
    add(4, 0, 0, 0, 1, 2,  4, 0, 0, 0, "clamp_low");
    add(4, 0, 0, 0, 1, 25, 20, 0, 0, 0, "clamp_high");
    add(4, 0, 1, 0, 1, 10, 10, 0, 0, 0, "load_over_en");
    add(4, 0, 1, 0, 0, 0, 11, 0, 0, 0, "step_after_load");
    add(4, 0, 0, 0, 1, 17, 17, 0, 0, 0, "load17");
    add(4, 1, 1, 0, 1, 9,  4, 0, 0, 0, "reset_over_load_en");
    add(4, 0, 0, 0, 1, 20, 20, 0, 0, 0, "load_end");
    add(4, 0, 1, 0, 0, 0,  4, 0, 0, 0, "wrap_up_no_tc");
    add(4, 0, 1, 1, 0, 0, 20, 0, 0, 1, "wrap_dn_no_tc");
    add(4, 0, 1, 1, 0, 0, 19, 0, 0, 1, "wrap_dn19");

    for (int u = 0; u < NU; u++) begin
      t_rst[u] = 1'b1; t_en[u] = 1'b0; t_down[u] = 1'b0;
      t_load[u] = 1'b0; t_lval[u] = 5'd0;
    end
    repeat (2) @(posedge clk);

    foreach (vecs[i]) apply(vecs[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
